stream_from_memory_pipelined: RTL and testbench

- Parametrised successor to the single-word memory-to-stream reader.
- Fetches a programmed number of words from memory through a pipelined Avalon-MM read master, with multiple reads outstanding and a configurable byte stride. Returned data is buffered in an internal FIFO.
- Emits one Avalon-ST packet (sop on first word, eop on last word) with full ready/valid backpressure.
- Controlled by a CSR slave and sits between system memory and the inference-engine streaming datapath.

---
 rtl/stream_from_memory_pipelined.sv | 194 +++++++++++++++++++
 tb/tb_stream_from_memory_pipelined.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_from_memory_pipelined.sv
// stream_from_memory_pipelined
//   Fetches a programmed number of words from memory through a pipelined
//   Avalon-MM read master (several reads in flight, byte stride), buffers the
//   returned words in a show-ahead FIFO and emits them as one Avalon-ST packet.
// Ports:
//   clock, clock_sreset        system clock, synchronous active-high reset
//   s_*                        CSR slave: 0 ctrl/status, 1 pointer, 2 count, 3 stride
//   rm_*                       pipelined Avalon-MM read master
//   st_*                       Avalon-ST source (valid/ready, sop/eop)
module stream_from_memory_pipelined #(
  parameter int DATA_W     = 16,
  parameter int COUNT_W    = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clock,
  input  logic                clock_sreset,
  input  logic [3:0]          s_address,
  output logic [31:0]         s_readdata,
  input  logic [31:0]         s_writedata,
  input  logic                s_read,
  input  logic                s_write,
  output logic                s_waitrequest,
  output logic [31:0]         rm_address,
  input  logic [DATA_W-1:0]   rm_readdata,
  output logic [DATA_W/8-1:0] rm_byteenable,
  output logic                rm_read,
  input  logic                rm_waitrequest,
  input  logic                rm_readdatavalid,
  input  logic                st_ready,
  output logic                st_valid,
  output logic                st_sop,
  output logic                st_eop,
  output logic [DATA_W-1:0]   st_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [31:0]          pointer_q;
  logic [COUNT_W-1:0]   count_q;
  logic [15:0]          stride_q;
  logic [31:0]          addr_q;
  logic [15:0]          wStride_q;
  logic [COUNT_W-1:0]   total_q;
  logic [COUNT_W-1:0]   issued_q;
  logic [COUNT_W-1:0]   sent_q;
  logic [PW-1:0]        pending_q, pending_d;
  logic [PW-1:0]        used_q, used_d;
  logic [AW-1:0]        wrPtr_q, rdPtr_q;
  logic [DATA_W-1:0]    fifoMem_q [FIFO_DEPTH];
  logic                 abort_q;
  logic                 hold_q;
  logic                 rdAck_q;
  logic [31:0]          readData_q;

  logic                 busy, csrCtrlWr, goReq, abortReq;
  logic                 accept, beat, push, pop, credit;
  logic [31:0]          readMux;

  // Control decode. Go only starts from IDLE with a non-zero count; abort
  // only matters while a transfer is active and not already aborting.
  // A returning beat is only meaningful while busy with reads outstanding,
  // which also makes stray beats after a reset harmless.
  always_comb begin
    busy      = (state_q != IDLE);
    csrCtrlWr = s_write && (s_address == 4'd0);
    goReq     = csrCtrlWr && s_writedata[0] && !busy && (count_q != '0);
    abortReq  = csrCtrlWr && s_writedata[1] && busy && !abort_q;
    accept    = rm_read && !rm_waitrequest;
    beat      = rm_readdatavalid && busy && (pending_q != '0);
    push      = beat && !abort_q && !abortReq;
    pop       = st_valid && st_ready;
    credit    = ({1'b0, pending_q} + {1'b0, used_q}) < (PW + 1)'(FIFO_DEPTH);
  end

  // Read request: a new request needs FIFO credit so every outstanding word
  // has a guaranteed slot; a request already stalled by waitrequest is held
  // until accepted, even if an abort arrived meanwhile.
  always_comb begin
    rm_read       = (state_q == READ) && ((!abort_q && credit) || hold_q);
    rm_address    = addr_q;
    rm_byteenable = '1;
    st_valid      = (used_q != '0);
    st_data       = fifoMem_q[rdPtr_q];
    st_sop        = st_valid && (sent_q == '0);
    st_eop        = st_valid && (sent_q == total_q - COUNT_W'(1));
    s_waitrequest = s_read && !rdAck_q;
    s_readdata    = readData_q;
  end

  // Next-state logic. An abort finishes as soon as nothing is in flight and
  // no request is still being presented to the memory.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (goReq) state_d = READ;
      READ:    if (accept && (issued_q == total_q - COUNT_W'(1))) state_d = DRAIN;
      DRAIN:   if (sent_q == total_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_q && (pending_q == '0) && !rm_read) state_d = IDLE;
  end

  // Outstanding-read and FIFO occupancy bookkeeping. An accept and a return
  // in the same cycle cancel out; an abort flushes the FIFO.
  always_comb begin
    pending_d = pending_q;
    if (accept && !beat) pending_d = pending_q + PW'(1);
    else if (!accept && beat) pending_d = pending_q - PW'(1);
    used_d = used_q;
    if (push && !pop) used_d = used_q + PW'(1);
    else if (!push && pop) used_d = used_q - PW'(1);
    if (abortReq) used_d = '0;
  end

  // CSR read mux, sampled during the waitrequest cycle and returned a cycle later.
  always_comb begin
    readMux = '0;
    unique case (s_address)
      4'd0:    readMux = {29'b0, abort_q, busy, 1'b0};
      4'd1:    readMux = pointer_q;
      4'd2:    readMux = 32'(count_q);
      4'd3:    readMux = {16'b0, stride_q};
      default: readMux = '0;
    endcase
  end

  // Main sequential state: CSR registers, working copies, counters, FIFO
  // pointers and the abort/hold flags.
  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      state_q    <= IDLE;
      pointer_q  <= '0;
      count_q    <= '0;
      stride_q   <= 16'(DATA_W / 8);
      addr_q     <= '0;
      wStride_q  <= '0;
      total_q    <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      pending_q  <= '0;
      used_q     <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      abort_q    <= 1'b0;
      hold_q     <= 1'b0;
      rdAck_q    <= 1'b0;
      readData_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      used_q    <= used_d;
      hold_q    <= rm_read && rm_waitrequest;
      rdAck_q   <= s_read && !rdAck_q;
      if (s_read && !rdAck_q) readData_q <= readMux;
      if (s_write && !busy) begin
        if (s_address == 4'd1) pointer_q <= s_writedata;
        if (s_address == 4'd2) count_q <= s_writedata[COUNT_W-1:0];
        if (s_address == 4'd3) stride_q <= s_writedata[15:0];
      end
      if (goReq) begin
        addr_q    <= pointer_q;
        wStride_q <= stride_q;
        total_q   <= count_q;
        issued_q  <= '0;
        sent_q    <= '0;
      end else begin
        if (accept) begin
          addr_q   <= addr_q + 32'(wStride_q);
          issued_q <= issued_q + COUNT_W'(1);
        end
        if (pop) sent_q <= sent_q + COUNT_W'(1);
      end
      if (abortReq) abort_q <= 1'b1;
      else if (abort_q && (state_d == IDLE)) abort_q <= 1'b0;
      if (abortReq) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
      end else begin
        if (push) wrPtr_q <= wrPtr_q + AW'(1);
        if (pop) rdPtr_q <= rdPtr_q + AW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) fifoMem_q[wrPtr_q] <= rm_readdata;
  end

endmodule

// File: tb/tb_stream_from_memory_pipelined.sv
// tb_stream_from_memory_pipelined
//   Drives stream_from_memory_pipelined with a latency-configurable memory
//   model, random waitrequest/ready, and compares the issued addresses and the
//   streamed packet against a list computed from pointer + i*stride.
module tb_stream_from_memory_pipelined;

  localparam int DATA_W     = 16;
  localparam int COUNT_W    = 24;
  localparam int FIFO_DEPTH = 16;

  logic                clock = 1'b0;
  logic                clock_sreset;
  logic [3:0]          s_address;
  logic [31:0]         s_readdata;
  logic [31:0]         s_writedata;
  logic                s_read, s_write, s_waitrequest;
  logic [31:0]         rm_address;
  logic [DATA_W-1:0]   rm_readdata;
  logic [DATA_W/8-1:0] rm_byteenable;
  logic                rm_read, rm_waitrequest, rm_readdatavalid;
  logic                st_ready, st_valid, st_sop, st_eop;
  logic [DATA_W-1:0]   st_data;

  stream_from_memory_pipelined #(
    .DATA_W(DATA_W), .COUNT_W(COUNT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock), .clock_sreset(clock_sreset),
    .s_address(s_address), .s_readdata(s_readdata), .s_writedata(s_writedata),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .rm_address(rm_address), .rm_readdata(rm_readdata), .rm_byteenable(rm_byteenable),
    .rm_read(rm_read), .rm_waitrequest(rm_waitrequest), .rm_readdatavalid(rm_readdatavalid),
    .st_ready(st_ready), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_data(st_data)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int due; } resp_t;
  typedef struct { logic [DATA_W-1:0] data; logic sop; logic eop; int cyc; } word_t;

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;
  int stallPct = 0, readyPct = 100, memLat = 3;
  int forceStallIdx = -1, forceStallLeft = 0, forceBad = 0;
  logic [31:0] forceExpAddr;
  int maxInFlight = 0, holdViolRm = 0, holdViolSt = 0;
  resp_t respQ[$];
  logic [31:0] acceptQ[$];
  word_t streamQ[$];
  logic sWaitS, stValidS, stSopS, stEopS, rmReadS;
  logic [31:0] sReadDataS;
  logic prevRmStall = 1'b0, prevStStall = 1'b0, prevDisturb = 1'b0;
  logic [31:0] prevRmAddr;
  logic [DATA_W-1:0] prevStData;
  logic prevStSop, prevStEop;

  // Counts every comparison and reports each mismatch on one line.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Contents of the modelled memory at a byte address.
  function automatic logic [DATA_W-1:0] memWord(input logic [31:0] a);
    logic [31:0] t;
    t = a * 32'h9E3779B1;
    t = t ^ (t >> 15);
    return t[DATA_W-1:0];
  endfunction

  // One clock cycle: drive memory/sink inputs after the falling edge, look at
  // the settled outputs 1 ns later, record accepted reads and transferred words.
  task automatic applyStimulus();
    resp_t r;
    word_t w;
    int inflight;
    if (forceStallLeft > 0 && acceptQ.size() == forceStallIdx) rm_waitrequest = 1'b1;
    else rm_waitrequest = ($urandom_range(99) < stallPct);
    st_ready = ($urandom_range(99) < readyPct);
    if (respQ.size() > 0 && respQ[0].due <= cycleNo) begin
      r = respQ.pop_front();
      rm_readdatavalid = 1'b1;
      rm_readdata = memWord(r.addr);
    end else begin
      rm_readdatavalid = 1'b0;
      rm_readdata = DATA_W'($urandom);
    end
    #1;
    if (prevRmStall && !prevDisturb && (!rm_read || rm_address !== prevRmAddr)) holdViolRm++;
    if (prevStStall && !prevDisturb &&
        (!st_valid || st_data !== prevStData || st_sop !== prevStSop || st_eop !== prevStEop))
      holdViolSt++;
    if (forceStallLeft > 0 && acceptQ.size() == forceStallIdx && rm_read) begin
      forceStallLeft--;
      if (rm_address !== forceExpAddr) forceBad++;
    end
    if (rm_read && !rm_waitrequest) begin
      acceptQ.push_back(rm_address);
      r.addr = rm_address;
      r.due = cycleNo + memLat;
      respQ.push_back(r);
    end
    if (st_valid && st_ready) begin
      w.data = st_data; w.sop = st_sop; w.eop = st_eop; w.cyc = cycleNo;
      streamQ.push_back(w);
    end
    inflight = acceptQ.size() - streamQ.size();
    if (inflight > maxInFlight) maxInFlight = inflight;
    sWaitS = s_waitrequest; sReadDataS = s_readdata;
    stValidS = st_valid; stSopS = st_sop; stEopS = st_eop; rmReadS = rm_read;
    prevRmStall = rm_read && rm_waitrequest;
    prevRmAddr = rm_address;
    prevStStall = st_valid && !st_ready;
    prevStData = st_data; prevStSop = st_sop; prevStEop = st_eop;
    prevDisturb = clock_sreset || (s_write && s_address == 4'd0);
    @(negedge clock);
    cycleNo++;
  endtask

  task automatic csrWrite(input logic [3:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    applyStimulus();
    s_write = 1'b0;
  endtask

  task automatic csrRead(input logic [3:0] a, output logic [31:0] d, output logic waitOk);
    logic w1, w2;
    s_address = a; s_read = 1'b1;
    applyStimulus();
    w1 = sWaitS;
    applyStimulus();
    w2 = sWaitS;
    d = sReadDataS;
    s_read = 1'b0;
    waitOk = (w1 == 1'b1) && (w2 == 1'b0);
  endtask

  task automatic startTransfer(input logic [31:0] ptr, input int cnt, input logic [15:0] stride);
    acceptQ.delete(); streamQ.delete();
    maxInFlight = 0; holdViolRm = 0; holdViolSt = 0;
    csrWrite(4'd1, ptr);
    csrWrite(4'd2, 32'(cnt));
    csrWrite(4'd3, {16'h0, stride});
    csrWrite(4'd0, 32'h1);
  endtask

  // Waits for the whole packet, lets the block settle, then compares against
  // the expected address/word list.
  task automatic checkOutputTransfer(input string name, input logic [31:0] ptr, input int cnt,
                                     input logic [15:0] stride);
    int budget;
    logic [31:0] st, expAddr;
    logic ok;
    budget = 0;
    while (streamQ.size() < cnt && budget < 4000) begin applyStimulus(); budget++; end
    checkOutput({name, "_timeout"}, budget < 4000, 1);
    for (int k = 0; k < 6; k++) applyStimulus();
    csrRead(4'd0, st, ok);
    checkOutput({name, "_idle"}, st, 32'h0);
    checkOutput({name, "_nReads"}, acceptQ.size(), cnt);
    checkOutput({name, "_nWords"}, streamQ.size(), cnt);
    for (int i = 0; i < cnt && i < acceptQ.size() && i < streamQ.size(); i++) begin
      expAddr = ptr + 32'(i) * 32'(stride);
      checkOutput($sformatf("%s_addr%0d", name, i), acceptQ[i], expAddr);
      checkOutput($sformatf("%s_data%0d", name, i), streamQ[i].data, memWord(expAddr));
      checkOutput($sformatf("%s_sop%0d", name, i), streamQ[i].sop, i == 0);
      checkOutput($sformatf("%s_eop%0d", name, i), streamQ[i].eop, i == cnt - 1);
    end
    checkOutput({name, "_holdRm"}, holdViolRm, 0);
    checkOutput({name, "_holdSt"}, holdViolSt, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] d, st;
    logic ok;
    int budget, atAbort, eops;
    clock_sreset = 1'b1; s_address = '0; s_writedata = '0; s_read = 1'b0; s_write = 1'b0;
    rm_waitrequest = 1'b0; rm_readdatavalid = 1'b0; rm_readdata = '0; st_ready = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 3; k++) applyStimulus();
    clock_sreset = 1'b0;
    applyStimulus();
    checkOutput("rst_rmRead", rmReadS, 0);
    checkOutput("rst_stValid", stValidS, 0);
    checkOutput("rst_sop", stSopS, 0);
    checkOutput("rst_eop", stEopS, 0);
    checkOutput("rst_sWait", sWaitS, 0);
    csrRead(4'd3, d, ok); checkOutput("rst_stride", d, DATA_W / 8);
    csrRead(4'd1, d, ok); checkOutput("rst_pointer", d, 0);
    csrRead(4'd0, d, ok); checkOutput("rst_status", d, 0);

    // CSR readback with one-cycle waitrequest on reads, none on writes
    csrWrite(4'd1, 32'h1234_5678); checkOutput("csr_wrNoWait", sWaitS, 0);
    csrWrite(4'd2, 32'hFFFF_FFFF);
    csrWrite(4'd3, 32'hABCD_1234);
    csrWrite(4'd7, 32'hFFFF_FFFF);
    csrRead(4'd1, d, ok); checkOutput("csr_ptr", d, 32'h1234_5678); checkOutput("csr_ptrWait", ok, 1);
    csrRead(4'd2, d, ok); checkOutput("csr_cnt", d, 32'h00FF_FFFF); checkOutput("csr_cntWait", ok, 1);
    csrRead(4'd3, d, ok); checkOutput("csr_stride", d, 32'h0000_1234); checkOutput("csr_strWait", ok, 1);
    csrRead(4'd7, d, ok); checkOutput("csr_unmapped", d, 0);

    // Basic transfer, busy during the transfer, one word per cycle
    memLat = 3; stallPct = 0; readyPct = 100;
    startTransfer(32'h1000, 4, 16'd2);
    csrRead(4'd0, st, ok);
    checkOutput("basic_busy", st, 32'h2);
    checkOutputTransfer("basic", 32'h1000, 4, 16'd2);
    if (streamQ.size() == 4) checkOutput("basic_span", streamQ[3].cyc - streamQ[0].cyc, 3);

    // Backpressure: credit limits reads to the FIFO depth
    readyPct = 0;
    startTransfer(32'h1000, 40, 16'd2);
    for (int k = 0; k < 60; k++) applyStimulus();
    checkOutput("bp_reads", acceptQ.size(), FIFO_DEPTH);
    checkOutput("bp_noWords", streamQ.size(), 0);
    checkOutput("bp_maxInFlight", maxInFlight <= FIFO_DEPTH, 1);
    readyPct = 100;
    checkOutputTransfer("bp", 32'h1000, 40, 16'd2);

    // Master stall on the second read
    forceStallIdx = 1; forceStallLeft = 5; forceBad = 0; forceExpAddr = 32'h1002;
    startTransfer(32'h1000, 8, 16'd2);
    checkOutputTransfer("mstall", 32'h1000, 8, 16'd2);
    checkOutput("mstall_cycles", forceStallLeft, 0);
    checkOutput("mstall_addrHeld", forceBad, 0);
    forceStallIdx = -1;

    // Boundaries: single word, zero count, go and writes while busy, address wrap
    startTransfer(32'h2000, 1, 16'd4);
    checkOutputTransfer("one", 32'h2000, 1, 16'd4);
    acceptQ.delete(); streamQ.delete();
    csrWrite(4'd2, 32'h0);
    csrWrite(4'd0, 32'h1);
    for (int k = 0; k < 10; k++) applyStimulus();
    checkOutput("zero_reads", acceptQ.size(), 0);
    csrRead(4'd0, d, ok); checkOutput("zero_status", d, 0);
    startTransfer(32'h3000, 20, 16'd4);
    for (int k = 0; k < 3; k++) applyStimulus();
    csrWrite(4'd1, 32'hDEAD_0000);
    csrWrite(4'd0, 32'h1);
    checkOutputTransfer("busyGo", 32'h3000, 20, 16'd4);
    for (int k = 0; k < 10; k++) applyStimulus();
    checkOutput("busyGo_noSecond", acceptQ.size(), 20);
    csrRead(4'd1, d, ok); checkOutput("busyGo_ptrKept", d, 32'h3000);
    startTransfer(32'hFFFF_FFFE, 2, 16'd2);
    checkOutputTransfer("wrap", 32'hFFFF_FFFE, 2, 16'd2);

    // Randomized transfers
    for (int n = 0; n < 6; n++) begin
      logic [31:0] p;
      int c;
      logic [15:0] s;
      p = $urandom; c = $urandom_range(1, 30); s = 16'($urandom_range(0, 65535));
      stallPct = $urandom_range(0, 40); readyPct = $urandom_range(20, 100);
      memLat = $urandom_range(1, 6);
      startTransfer(p, c, s);
      checkOutputTransfer($sformatf("rnd%0d", n), p, c, s);
    end

    // Abort after ten words
    memLat = 8; stallPct = 0; readyPct = 100;
    startTransfer(32'h4000, 100, 16'd2);
    budget = 0;
    while (streamQ.size() < 10 && budget < 500) begin applyStimulus(); budget++; end
    checkOutput("abort_reach10", budget < 500, 1);
    csrWrite(4'd0, 32'h2);
    atAbort = acceptQ.size();
    applyStimulus();
    checkOutput("abort_stValid", stValidS, 0);
    checkOutput("abort_rmRead", rmReadS, 0);
    csrRead(4'd0, st, ok);
    checkOutput("abort_pendingFlag", st, 32'h6);
    budget = 0;
    while (st != 0 && budget < 50) begin csrRead(4'd0, st, ok); budget++; end
    checkOutput("abort_cleared", st, 0);
    checkOutput("abort_noMoreReads", acceptQ.size(), atAbort);
    checkOutput("abort_allReturned", respQ.size(), 0);
    eops = 0;
    for (int i = 0; i < streamQ.size(); i++) begin
      if (streamQ[i].eop) eops++;
      checkOutput($sformatf("abort_data%0d", i), streamQ[i].data, memWord(32'h4000 + 32'(2 * i)));
      checkOutput($sformatf("abort_sop%0d", i), streamQ[i].sop, i == 0);
    end
    checkOutput("abort_noEop", eops, 0);
    memLat = 3;
    startTransfer(32'h5000, 3, 16'd2);
    checkOutputTransfer("postAbort", 32'h5000, 3, 16'd2);

    // Reset in the middle of a transfer
    startTransfer(32'h6000, 40, 16'd2);
    for (int k = 0; k < 15; k++) applyStimulus();
    clock_sreset = 1'b1;
    applyStimulus();
    clock_sreset = 1'b0;
    applyStimulus();
    checkOutput("midRst_rmRead", rmReadS, 0);
    checkOutput("midRst_stValid", stValidS, 0);
    checkOutput("midRst_sop", stSopS, 0);
    checkOutput("midRst_eop", stEopS, 0);
    checkOutput("midRst_sWait", sWaitS, 0);
    csrRead(4'd3, d, ok); checkOutput("midRst_stride", d, DATA_W / 8);
    csrRead(4'd2, d, ok); checkOutput("midRst_count", d, 0);
    csrRead(4'd0, d, ok); checkOutput("midRst_status", d, 0);
    budget = 0;
    while (respQ.size() > 0 && budget < 50) begin applyStimulus(); budget++; end
    startTransfer(32'h7000, 5, 16'd2);
    checkOutputTransfer("postRst", 32'h7000, 5, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
